// File: rtl/note_scroller.sv
// rtl/note_scroller.sv - falling-note lane scroller with hit-marker consume and saturating miss counter
// Rows shift toward row 0 once per step; row DEPTH-1 is fed from the pattern stream.
module note_scroller #(
  parameter int LANES       = 4,
  parameter int DEPTH       = 16,
  parameter int STEP_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   start,
  input  logic [LANES-1:0]       pattern_data,
  input  logic                   pattern_valid,
  input  logic                   pattern_last,
  output logic                   pattern_ready,
  input  logic [LANES-1:0]       consume,
  output logic [LANES-1:0]       at_marker,
  output logic [LANES*DEPTH-1:0] lane_rows,
  output logic                   miss_pulse,
  output logic [7:0]             miss_count,
  output logic                   running,
  output logic                   done
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam int PW = $clog2(LANES + 1);
  localparam int RW = LANES * DEPTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rows_q, rows_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      miss_q, miss_d;
  logic            pulse_q, pulse_d;

  logic            active;
  logic            step;
  logic            transfer;
  logic [LANES-1:0] row0_kept;
  logic [LANES-1:0] top_row;
  logic [PW-1:0]   miss_pop;
  logic [8:0]      miss_sum;

  assign active        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign step          = active && (cnt_q == LAST_CNT);
  assign pattern_ready = (state_q == S_RUN) && step;
  assign transfer      = pattern_ready && pattern_valid;
  assign top_row       = transfer ? pattern_data : '0;
  // Consume is applied first, so whatever survives in row 0 on a step is a miss.
  assign row0_kept     = rows_q[LANES-1:0] & ~consume;

  always_comb begin
    miss_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      miss_pop = miss_pop + PW'(row0_kept[l]);
    end
  end

  assign miss_sum = {1'b0, miss_q} + 9'(miss_pop);

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          rows_d  = '0;
          cnt_d   = '0;
          miss_d  = '0;
        end
      end
      S_RUN, S_DRAIN: begin
        if (step) begin
          rows_d  = {top_row, rows_q[RW-1:LANES]};
          cnt_d   = '0;
          pulse_d = |row0_kept;
          miss_d  = miss_sum[8] ? 8'hFF : miss_sum[7:0];
          if (transfer && pattern_last) begin
            state_d = S_DRAIN;
          end else if ((state_q == S_DRAIN) && (rows_q[RW-1:LANES] == '0)) begin
            state_d = S_DONE;
          end
        end else begin
          rows_d[LANES-1:0] = row0_kept;
          cnt_d             = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      pulse_q <= pulse_d;
    end
  end

  assign at_marker  = rows_q[LANES-1:0];
  assign lane_rows  = rows_q;
  assign miss_pulse = pulse_q;
  assign miss_count = miss_q;
  assign running    = active;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_note_scroller.sv
// tb/tb_note_scroller.sv - directed and randomized checks of note_scroller against a behavioural model
module tb_note_scroller;
  localparam int LANES = 4;
  localparam int DEPTH = 16;
  localparam int STEP  = 4;

  logic                   clk = 1'b0;
  logic                   resetb;
  logic                   start;
  logic [LANES-1:0]       pattern_data;
  logic                   pattern_valid;
  logic                   pattern_last;
  logic                   pattern_ready;
  logic [LANES-1:0]       consume;
  logic [LANES-1:0]       at_marker;
  logic [LANES*DEPTH-1:0] lane_rows;
  logic                   miss_pulse;
  logic [7:0]             miss_count;
  logic                   running;
  logic                   done;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 run, 2 drain, 3 done; m_t counts cycles since the song started.
  int               m_state;
  logic [LANES-1:0] m_rows [DEPTH];
  int               m_t;
  int               m_miss;
  bit               m_pulse;

  note_scroller #(.LANES(LANES), .DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .resetb(resetb), .start(start),
    .pattern_data(pattern_data), .pattern_valid(pattern_valid), .pattern_last(pattern_last),
    .pattern_ready(pattern_ready), .consume(consume), .at_marker(at_marker),
    .lane_rows(lane_rows), .miss_pulse(miss_pulse), .miss_count(miss_count),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    for (int d = 0; d < DEPTH; d++) m_rows[d] = '0;
    m_t     = 0;
    m_miss  = 0;
    m_pulse = 0;
  endtask

  function automatic bit m_ready();
    return (m_state == 1) && ((m_t % STEP) == STEP - 1);
  endfunction

  function automatic logic [63:0] m_flat();
    logic [63:0] f;
    f = '0;
    for (int d = 0; d < DEPTH; d++) f[d*LANES +: LANES] = m_rows[d];
    return f;
  endfunction

  task automatic m_clock();
    logic [LANES-1:0] row0;
    bit stp, take, was_drain, empty;
    if (!resetb) begin
      m_reset();
      return;
    end
    m_pulse = 0;
    if (m_state == 0 || m_state == 3) begin
      if (start) begin
        m_state = 1;
        for (int d = 0; d < DEPTH; d++) m_rows[d] = '0;
        m_t    = 0;
        m_miss = 0;
      end
      return;
    end
    row0 = m_rows[0] & ~consume;
    stp  = (m_t % STEP) == STEP - 1;
    take = (m_state == 1) && stp && pattern_valid;
    m_t++;
    if (!stp) begin
      m_rows[0] = row0;
      return;
    end
    m_pulse = (row0 != 0);
    m_miss  = m_miss + $countones(row0);
    if (m_miss > 255) m_miss = 255;
    was_drain = (m_state == 2);
    for (int d = 0; d < DEPTH - 1; d++) m_rows[d] = m_rows[d+1];
    m_rows[DEPTH-1] = take ? pattern_data : '0;
    empty = 1;
    for (int d = 0; d < DEPTH; d++) if (m_rows[d] != 0) empty = 0;
    if (take && pattern_last) m_state = 2;
    else if (was_drain && empty) m_state = 3;
  endtask

  task automatic compare_all();
    check("pattern_ready", pattern_ready, m_ready());
    check("at_marker", at_marker, m_rows[0]);
    check("lane_rows", lane_rows, m_flat());
    check("miss_pulse", miss_pulse, m_pulse);
    check("miss_count", miss_count, m_miss);
    check("running", running, (m_state == 1 || m_state == 2));
    check("done", done, m_state == 3);
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    start = 0; pattern_data = '0; pattern_valid = 0; pattern_last = 0; consume = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    resetb = 0;
    m_reset();
    #1;
    compare_all();
    @(negedge clk);
    resetb = 1;
  endtask

  task automatic start_song();
    start = 1;
    tick();
    start = 0;
  endtask

  // Holds valid until the next ready cycle has been crossed, then drops it.
  task automatic inject(input logic [LANES-1:0] data, input bit last);
    bit was;
    pattern_data = data; pattern_valid = 1; pattern_last = last;
    for (int i = 0; i < 2 * STEP; i++) begin
      was = m_ready();
      tick();
      if (was) break;
    end
    pattern_valid = 0; pattern_last = 0; pattern_data = '0;
  endtask

  initial begin
    clear_inputs();
    resetb = 0;
    m_reset();
    #12;
    compare_all();
    @(negedge clk);
    resetb = 1;
    ticks(3);

    // Untouched note reaches the marker after step 16, exits as a miss on step 17.
    start_song();
    inject(4'b0001, 0);
    ticks(15 * STEP);
    check("marker_step16", at_marker, 4'b0001);
    ticks(STEP);
    check("miss_pulse_step17", miss_pulse, 1);
    check("miss_count_step17", miss_count, 1);
    tick();

    // Consume on the step cycle itself prevents the miss.
    do_reset();
    start_song();
    inject(4'b0001, 0);
    ticks(15 * STEP);
    ticks(STEP - 1);
    consume = 4'b0001;
    tick();
    consume = '0;
    check("hit_marker", at_marker, 0);
    check("hit_no_pulse", miss_pulse, 0);
    check("hit_no_count", miss_count, 0);

    // Consume on an empty lane leaves the note in place.
    do_reset();
    start_song();
    inject(4'b0001, 0);
    ticks(15 * STEP);
    consume = 4'b1000;
    tick();
    consume = '0;
    check("wrong_lane_marker", at_marker, 4'b0001);
    ticks(STEP - 1);
    check("wrong_lane_miss", miss_count, 1);

    // 65 full rows missed: counter saturates and stays.
    do_reset();
    start_song();
    pattern_data = 4'b1111; pattern_valid = 1;
    ticks(65 * STEP);
    pattern_valid = 0; pattern_data = '0;
    ticks(16 * STEP);
    check("sat_255", miss_count, 255);
    ticks(2 * STEP);
    check("sat_hold", miss_count, 255);

    // Last row drains the song to DONE, restart clears the count.
    do_reset();
    start_song();
    inject(4'b0110, 1);
    check("drain_running", running, 1);
    check("drain_not_done", done, 0);
    ticks(16 * STEP);
    check("done_after17", done, 1);
    check("done_misses", miss_count, 2);
    consume = 4'b1111; pattern_valid = 1; pattern_data = 4'b1111;
    ticks(6);
    clear_inputs();
    start_song();
    check("restart_running", running, 1);
    check("restart_count", miss_count, 0);

    // Asynchronous reset mid-song between clock edges.
    do_reset();
    start_song();
    pattern_data = 4'b1111; pattern_valid = 1;
    ticks(20 * STEP);
    clear_inputs();
    #2;
    resetb = 0;
    #1;
    check("async_rows", lane_rows, 0);
    check("async_count", miss_count, 0);
    check("async_running", running, 0);
    check("async_ready", pattern_ready, 0);
    m_reset();
    @(negedge clk);
    resetb = 1;
    ticks(5);

    // Randomized songs with random hits, gaps and stray starts.
    for (int song = 0; song < 6; song++) begin
      start_song();
      for (int c = 0; c < 2000; c++) begin
        pattern_valid = ($urandom_range(0, 1) == 1);
        pattern_data  = LANES'($urandom_range(0, 15));
        pattern_last  = ($urandom_range(0, 29) == 0);
        consume       = LANES'($urandom_range(0, 15)) & (($urandom_range(0, 2) == 0) ? 4'hF : 4'h0);
        start         = ($urandom_range(0, 19) == 0);
        tick();
        if (m_state == 3) break;
      end
      check("song_end", done, 1);
      for (int c = 0; c < 8; c++) begin
        pattern_valid = 1; pattern_data = 4'hF;
        consume = LANES'($urandom_range(0, 15));
        tick();
      end
      clear_inputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
NOTE_SCROLLER -- requirements
Module: note_scroller

Interface
REQ-001 SHALL have parameter LANES, 4, number of note lanes (keys).
REQ-002 SHALL have parameter DEPTH, 16, rows per lane; row 0 is the hit-marker row.
REQ-003 SHALL have parameter STEP_CYCLES, 4, clk cycles per scroll step (>=2).
REQ-004 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port resetb  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  level; begins a song from IDLE or DONE.
REQ-007 SHALL have port pattern_data  input  LANES  next note row to inject, bit l = lane l.
REQ-008 SHALL have port pattern_valid  input  1  pattern_data/pattern_last are valid.
REQ-009 SHALL have port pattern_last  input  1  accompanies the final pattern row.
REQ-010 SHALL have port pattern_ready  output  1  row accepted this cycle.
REQ-011 SHALL have port consume  input  LANES  hit-detector request to clear lane l at row 0.
REQ-012 SHALL have port at_marker  output  LANES  current row 0 contents.
REQ-013 SHALL have port lane_rows  output  LANES*DEPTH  all rows for drawing; bit d*LANES+l = row d, lane l.
REQ-014 SHALL have port miss_pulse  output  1  one-cycle pulse when at least one note exits unconsumed.
REQ-015 SHALL have port miss_count  output  8  saturating count of missed notes.
REQ-016 SHALL have port running  output  1  high in RUN or DRAIN.
REQ-017 SHALL have port done  output  1  high in DONE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN and DONE->RUN SHALL occur on the edge where start=1; entering RUN clears all rows, the step counter and miss_count.
REQ-020 Step counter SHALL count 0..STEP_CYCLES-1 in RUN/DRAIN only; a step cycle is counter==STEP_CYCLES-1; first step is STEP_CYCLES cycles after entering RUN.
REQ-021 On a step cycle, row d SHALL take row d+1 (d<DEPTH-1); old row 0 is discarded.
REQ-022 pattern_ready SHALL equal (state==RUN and step cycle); transfer occurs when pattern_valid and pattern_ready.
REQ-023 On a step cycle, row DEPTH-1 SHALL load pattern_data on transfer, else all zeros (gap row, no error).
REQ-024 A transfer with pattern_last=1 SHALL move RUN->DRAIN at that edge.
REQ-025 DRAIN SHALL shift zeros each step; DRAIN->DONE on the step after which all rows are zero.
REQ-026 In RUN/DRAIN, every cycle, row 0 lane l SHALL clear when consume[l]=1; consume on an empty lane has no effect; consume is ignored in IDLE/DONE.
REQ-027 On a step cycle, consume SHALL be applied before miss evaluation: missed = row0 & ~consume.
REQ-028 miss_pulse SHALL be registered, high for the one cycle after a step cycle with missed!=0.
REQ-029 miss_count SHALL add popcount(missed) on that same edge, saturating at 255, never wrapping.
REQ-030 at_marker and lane_rows SHALL be driven directly from registers (zero combinational delay from state).
REQ-031 Steps, injection, consume and miss evaluation SHALL not occur in IDLE or DONE; rows hold their value.
REQ-032 start while in RUN/DRAIN SHALL be ignored.

Reset
REQ-033 resetb=0 SHALL immediately, independent of clk: state=IDLE, rows=0, step counter=0, miss_count=0, miss_pulse=0, pattern_ready=0.
REQ-034 Reset asserted mid-RUN SHALL abandon the song; no miss is counted for notes in flight.
REQ-035 After resetb rises, outputs SHALL hold reset values until start=1.

Verification (LANES=4, DEPTH=16, STEP_CYCLES=4)
REQ-036 Start, inject 4'b0001 on step 1 then valid=0 -> at_marker=4'b0001 after step 16; after step 17, miss_pulse one cycle, miss_count=1.
REQ-037 Same note, consume=4'b0001 asserted on step-17 cycle -> at_marker=0, no miss_pulse, miss_count=0.
REQ-038 consume=4'b1000 while at_marker=4'b0001 -> at_marker unchanged, then miss_count=1 at exit.
REQ-039 65 rows of 4'b1111 never consumed -> miss_count=255 after the 65th exit, stays 255.
REQ-040 Row 4'b0110 with pattern_last on step 1 -> DRAIN, running=1; done=1 after step 17; start=1 -> RUN, miss_count=0.
REQ-041 resetb low mid-RUN between clk edges -> lane_rows=0, miss_count=0, running=0 before next clk edge.
